pcap_fifo_rd_ctrl: RTL and testbench
====================================

Name: pcap_fifo_rd_ctrl

Overview:
Read-side sequencer for the replay engine's dual-clock width-converting FIFO, operating in the FIFO's read-clock domain. It issues rd_en against the FIFO's standard (non-FWFT) 1-cycle read latency and buffers returned words in a 2-entry output buffer. It presents the words as an AXI4-Stream master. A replay enable starts and stops the stream, and stopping only ever happens at packet boundaries. It also keeps word and packet counters for the register block.

Parameters:
DATA_WIDTH, 144, FIFO read word width; also m_axis_tdata width.
LAST_BIT, 143, bit index in the FIFO word that flags end of packet.
CNT_WIDTH, 32, width of the statistics counters.

Ports:
axi_aclk  in  1  clock; same as FIFO rd_clk.
axi_resetn  in  1  asynchronous active-low reset.
replay_en  in  1  level; 1 = stream packets, 0 = stop at next packet boundary.
clr_cnt  in  1  one-cycle pulse; synchronously clears both counters.
fifo_dout  in  DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_en  out  1  FIFO read strobe.
m_axis_tdata  out  DATA_WIDTH  buffered FIFO word (full word, LAST_BIT included).
m_axis_tlast  out  1  equals bit LAST_BIT of the head word.
m_axis_tvalid  out  1  head of buffer is valid.
m_axis_tready  in  1  downstream accept.
busy  out  1  high when state is not IDLE, a read is in flight, or the buffer is non-empty.
word_cnt  out  CNT_WIDTH  count of accepted beats.
pkt_cnt  out  CNT_WIDTH  count of accepted beats with tlast=1.

Behaviour:
- Reset (axi_resetn=0, asynchronous):
  - state=IDLE; buffer, in-flight flag, in_pkt and counters all cleared.
  - All outputs are 0.
  - Any read in flight at reset is discarded. The FIFO itself is not reset by this block.
- Capture: a read issued in cycle N puts fifo_dout into the buffer at the clock edge ending cycle N+1. The capture is unconditional, because credit is always reserved beforehand.
- Credit rule: fifo_rd_en = issue_ok & ~fifo_empty & (occ + inflight - pop < 2).
  - occ is the buffer occupancy (0..2).
  - inflight is 1 if a read was issued last cycle.
  - pop = m_axis_tvalid & m_axis_tready.
  - This creates a combinational path from m_axis_tready to fifo_rd_en, and it is allowed.
  - Under the rule the block sustains 1 word/cycle with tready held high.
- Output:
  - m_axis_tvalid = (occ != 0).
  - tdata and tlast come from the head entry and are held stable while tvalid=1 and tready=0.
  - Buffer order is FIFO; push and pop in the same cycle are legal.
- in_pkt: on capture, set to 1 if the captured word's LAST_BIT=0, cleared to 0 if LAST_BIT=1.
- State machine:
  - IDLE: issue_ok=0. Go to RUN when replay_en=1.
  - RUN: issue_ok=1. Go to HALT when replay_en=0; no read is issued in the cycle replay_en is seen low.
  - HALT: issue_ok=0. Once inflight=0, go to FINISH if in_pkt=1, otherwise go to IDLE.
  - FINISH:
    - Reads are issued one at a time: issue_ok = ~inflight, so no read is speculated past the tlast word.
    - When a word with LAST_BIT=1 is captured, go to IDLE.
    - replay_en returning to 1 while in FINISH is ignored until IDLE, which then re-enters RUN the next cycle.
  - In every state, the buffer keeps draining to downstream independently of the state.
- Counters:
  - word_cnt increments on each pop; pkt_cnt increments on each pop with tlast=1.
  - Both wrap modulo 2^CNT_WIDTH.
  - clr_cnt has priority: a pop in the clear cycle is not counted.
- FIFO empty mid-packet: stall with no rd_en; tvalid drops once the buffer drains; resume when not empty. This is not an error.
- fifo_rd_en is never asserted while fifo_empty=1.

Test Plan:
1. Reset with replay_en=0 and FIFO holding 3 words -> fifo_rd_en stays 0 and all outputs remain 0 indefinitely.
2. replay_en=1, FIFO preloaded with 4 packets of 5 words, tready=1 -> 20 beats back-to-back with no bubble after the first beat; tlast on beats 5, 10, 15, 20; word_cnt=20, pkt_cnt=4.
3. tready toggled by a random 50% pattern -> no beat lost or duplicated; tdata stable while stalled; occ never exceeds 2; fifo_rd_en never asserted while fifo_empty=1.
4. replay_en dropped after beat 2 of a 5-word packet -> words 3-5 still delivered, then fifo_rd_en stays 0; the next packet remains in the FIFO (fifo_empty=0); busy falls after beat 5 is accepted.
5. FIFO goes empty after word 2 of a packet for 10 cycles -> tvalid low during the gap, stream resumes correctly, pkt_cnt increments once.
6. clr_cnt pulsed coincident with a tlast beat, counters preset to 0xFFFFFFFF via wrap -> both counters read 0 next cycle; separately, a wrap case increments 0xFFFFFFFF to 0.
7. axi_resetn asserted mid-packet with a read in flight -> all outputs 0 immediately; after release, no stale word appears on m_axis.

Source files
------------

// File: rtl/pcap_fifo_rd_ctrl.sv
// Read-side sequencer for the replay FIFO: issues reads against a 1-cycle
// latency FIFO, buffers words in a 2-entry skid buffer and streams them as AXIS.
module pcap_fifo_rd_ctrl #(
  parameter int unsigned DATA_WIDTH = 144,
  parameter int unsigned LAST_BIT   = 143,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  axi_aclk,
  input  logic                  axi_resetn,
  input  logic                  replay_en,
  input  logic                  clr_cnt,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HALT, FINISH} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic                  r_in_pkt;
  logic [CNT_WIDTH-1:0]  r_word_cnt;
  logic [CNT_WIDTH-1:0]  r_pkt_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue_ok;
  logic                  w_cap_last;
  logic [2:0]            w_credit;

  assign w_pop      = m_axis_tvalid & m_axis_tready;
  assign w_push     = r_inflight;
  assign w_cap_last = r_inflight & fifo_dout[LAST_BIT];

  // Slots committed after this cycle: buffered + returning - leaving.
  assign w_credit   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd_en = w_issue_ok & ~fifo_empty & (w_credit < 3'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_issue_ok  = 1'b0;
    case (r_state)
      IDLE: begin
        if (replay_en) w_state_nxt = RUN;
      end
      RUN: begin
        w_issue_ok = replay_en;
        if (!replay_en) w_state_nxt = HALT;
      end
      HALT: begin
        if (!r_inflight) w_state_nxt = r_in_pkt ? FINISH : IDLE;
      end
      FINISH: begin
        // One read at a time so nothing is fetched past the tlast word.
        w_issue_ok = ~r_inflight;
        if (w_cap_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_in_pkt   <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_buf0 <= fifo_dout;
          else               r_buf1 <= fifo_dout;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= fifo_dout;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_dout;
          end
        end
        default: ;
      endcase
      r_inflight <= fifo_rd_en;
      if (w_push) r_in_pkt <= ~fifo_dout[LAST_BIT];
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_word_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (clr_cnt) begin
      r_word_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 1'b1;
      if (m_axis_tlast) r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  assign m_axis_tdata  = r_buf0;
  assign m_axis_tlast  = r_buf0[LAST_BIT];
  assign m_axis_tvalid = (r_occ != 2'd0);
  assign busy          = (r_state != IDLE) | r_inflight | (r_occ != 2'd0);
  assign word_cnt      = r_word_cnt;
  assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_pcap_fifo_rd_ctrl.sv
// Directed bench for pcap_fifo_rd_ctrl with a behavioural 1-cycle-latency FIFO;
// counters are narrowed to 8 bits so wrap cases are reachable.
module tb_pcap_fifo_rd_ctrl;

  localparam int unsigned DW = 144;
  localparam int unsigned LB = 143;
  localparam int unsigned CW = 8;

  logic          axi_aclk = 1'b0;
  logic          axi_resetn;
  logic          replay_en;
  logic          clr_cnt;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          busy;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] pkt_cnt;

  pcap_fifo_rd_ctrl #(.DATA_WIDTH(DW), .LAST_BIT(LB), .CNT_WIDTH(CW)) dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn), .replay_en(replay_en),
    .clr_cnt(clr_cnt), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy(busy), .word_cnt(word_cnt),
    .pkt_cnt(pkt_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  // Behavioural FIFO: standard read latency, not reset by the DUT reset.
  logic [DW-1:0] mem [0:1023];
  int unsigned   wp;
  int unsigned   rp;
  logic          tb_fifo_clr;

  always @(posedge axi_aclk) begin
    if (tb_fifo_clr) begin
      rp         <= 0;
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_rd_en) begin
        fifo_dout <= mem[rp[9:0]];
        rp        <= rp + 1;
      end
      fifo_empty <= ((fifo_rd_en ? rp + 1 : rp) == wp);
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned nbeats = 0;
  int unsigned rd_a = 0;
  int unsigned rd_b = 0;
  int unsigned occ_viol = 0;
  int unsigned stall_viol = 0;
  int unsigned rd_empty_viol = 0;
  int unsigned serial = 0;
  logic [31:0] lastmask = '0;
  logic        track = 1'b1;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int unsigned tag, input logic last);
    logic [DW-1:0] w;
    w = '0;
    w[31:0]    = $urandom;
    w[63:32]   = $urandom;
    w[95:64]   = $urandom;
    w[127:96]  = $urandom;
    w[142:128] = tag[14:0];
    w[LB]      = last;
    return w;
  endfunction

  task automatic push(input logic last);
    mem[wp[9:0]] = mk(serial, last);
    serial++;
    wp++;
  endtask

  task automatic push_pkt(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push(i == n - 1);
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic tick();
    int unsigned occ;
    @(negedge axi_aclk);
    if (track) begin
      occ = rd_a - nbeats;
      if (occ > 2 || m_axis_tvalid != (occ != 0)) occ_viol++;
    end
    if (fifo_rd_en && fifo_empty) rd_empty_viol++;
    if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data)) stall_viol++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    if (m_axis_tvalid && m_axis_tready) begin
      if (nbeats < wp) begin
        chk("beat_data", m_axis_tdata, mem[nbeats[9:0]]);
        chk("beat_last", DW'(m_axis_tlast), DW'(mem[nbeats[9:0]][LB]));
      end else begin
        chk("extra_beat", DW'(nbeats), DW'(wp));
      end
      if (m_axis_tlast && nbeats < 32) lastmask[nbeats[4:0]] = 1'b1;
      nbeats++;
    end
    rd_a = rd_b;
    rd_b = rd_b + (fifo_rd_en ? 1 : 0);
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic wait_beats(input int unsigned target, input string tag);
    int unsigned n;
    n = 0;
    while (nbeats < target && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, DW'(nbeats), DW'(target));
  endtask

  initial begin
    int unsigned n;
    int unsigned nz;
    int unsigned rd0;
    axi_resetn    = 1'b0;
    replay_en     = 1'b0;
    clr_cnt       = 1'b0;
    m_axis_tready = 1'b1;
    tb_fifo_clr   = 1'b1;
    wp            = 0;
    @(posedge axi_aclk);
    #1;
    tb_fifo_clr = 1'b0;

    // 1: reset and idle with three words waiting
    push(1'b0); push(1'b0); push(1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_tvalid", DW'(m_axis_tvalid), '0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tlast", DW'(m_axis_tlast), '0);
    chk("rst_rd_en", DW'(fifo_rd_en), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_word_cnt", DW'(word_cnt), '0);
    chk("rst_pkt_cnt", DW'(pkt_cnt), '0);
    axi_resetn = 1'b1;
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_axis_tvalid || m_axis_tlast || fifo_rd_en || busy || m_axis_tdata != '0 ||
          word_cnt != '0 || pkt_cnt != '0) nz++;
    end
    chk("t1_idle_outputs", DW'(nz), '0);
    chk("t1_fifo_untouched", DW'(rp), DW'(0));

    // 2: four 5-word packets, tready high
    push(1'b0); push(1'b1);
    for (int i = 0; i < 3; i++) push_pkt(5);
    replay_en = 1'b1;
    wait_beats(1, "t2_first_beat");
    n = 0;
    while (nbeats < 20 && n < 100) begin
      tick();
      n++;
    end
    chk("t2_span", DW'(n), DW'(19));
    chk("t2_tlast_pos", DW'(lastmask), DW'(32'h0008_4210));
    chk("t2_word_cnt", DW'(word_cnt), DW'(20));
    chk("t2_pkt_cnt", DW'(pkt_cnt), DW'(4));

    // 3: random backpressure over three packets
    for (int i = 0; i < 3; i++) push_pkt(5);
    n = 0;
    while (nbeats < 35 && n < 600) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("t3_beats", DW'(nbeats), DW'(35));
    m_axis_tready = 1'b1;
    tick(); tick();
    chk("t3_word_cnt", DW'(word_cnt), DW'(35));
    chk("t3_pkt_cnt", DW'(pkt_cnt), DW'(7));
    chk("t3_stall_hold", DW'(stall_viol), '0);
    chk("t3_rd_on_empty", DW'(rd_empty_viol), '0);
    chk("t3_occupancy", DW'(occ_viol), '0);

    // 4: stop request after beat 2 of a packet
    push_pkt(5);
    push_pkt(5);
    wait_beats(37, "t4_beat2");
    replay_en = 1'b0;
    wait_beats(40, "t4_beat5");
    chk("t4_busy_low", DW'(busy), '0);
    for (int i = 0; i < 20; i++) tick();
    chk("t4_no_more_beats", DW'(nbeats), DW'(40));
    chk("t4_reads_stopped", DW'(rp), DW'(wp - 5));
    chk("t4_fifo_not_empty", DW'(fifo_empty), '0);
    chk("t4_rd_en_low", DW'(fifo_rd_en), '0);
    chk("t4_pkt_cnt", DW'(pkt_cnt), DW'(8));

    // 5: restart, then FIFO runs dry mid-packet for 10 cycles
    replay_en = 1'b1;
    wait_beats(45, "t5_pkt_b");
    push(1'b0); push(1'b0);
    wait_beats(47, "t5_word2");
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_axis_tvalid || fifo_rd_en) nz++;
    end
    chk("t5_gap_idle", DW'(nz), '0);
    push(1'b0); push(1'b0); push(1'b1);
    wait_beats(50, "t5_resume");
    tick();
    chk("t5_pkt_cnt", DW'(pkt_cnt), DW'(10));
    chk("t5_word_cnt", DW'(word_cnt), DW'(50));

    // 6: counters to all-ones, clear on a tlast beat, then wrap
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t6_clr_idle_w", DW'(word_cnt), '0);
    for (int i = 0; i < 255; i++) push(1'b1);
    wait_beats(305, "t6_fill");
    tick();
    chk("t6_ones_w", DW'(word_cnt), DW'(8'hFF));
    chk("t6_ones_p", DW'(pkt_cnt), DW'(8'hFF));
    m_axis_tready = 1'b0;
    push(1'b1);
    n = 0;
    while (!m_axis_tvalid && n < 10) begin
      tick();
      n++;
    end
    chk("t6_pending", DW'(m_axis_tvalid), DW'(1));
    m_axis_tready = 1'b1;
    clr_cnt       = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t6_clr_beat", DW'(nbeats), DW'(306));
    chk("t6_clr_w", DW'(word_cnt), '0);
    chk("t6_clr_p", DW'(pkt_cnt), '0);
    for (int i = 0; i < 255; i++) push(1'b1);
    wait_beats(561, "t6_refill");
    tick();
    chk("t6_ones2_w", DW'(word_cnt), DW'(8'hFF));
    push(1'b1);
    wait_beats(562, "t6_wrap_beat");
    chk("t6_wrap_w", DW'(word_cnt), '0);
    chk("t6_wrap_p", DW'(pkt_cnt), '0);

    // 7: reset mid-packet with a read in flight
    m_axis_tready = 1'b0;
    rd0 = rd_b;
    push_pkt(5);
    n = 0;
    while (rd_b < rd0 + 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t7_two_reads", DW'(rd_b), DW'(rd0 + 2));
    track      = 1'b0;
    axi_resetn = 1'b0;
    #1;
    chk("t7_tvalid", DW'(m_axis_tvalid), '0);
    chk("t7_tdata", m_axis_tdata, '0);
    chk("t7_tlast", DW'(m_axis_tlast), '0);
    chk("t7_rd_en", DW'(fifo_rd_en), '0);
    chk("t7_busy", DW'(busy), '0);
    chk("t7_word_cnt", DW'(word_cnt), '0);
    chk("t7_pkt_cnt", DW'(pkt_cnt), '0);
    replay_en     = 1'b0;
    m_axis_tready = 1'b1;
    tick(); tick();
    axi_resetn = 1'b1;
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_axis_tvalid || busy || fifo_rd_en) nz++;
    end
    chk("t7_no_stale", DW'(nz), '0);
    chk("t7_beats", DW'(nbeats), DW'(562));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
